// File: rtl/wb_b3_line_fetch.sv
// Wishbone B3 wrapped-burst line fetcher, critical word first.
// Streams each acked beat out one cycle later; aborts on err/rty/timeout.
module wb_b3_line_fetch #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int BEATS   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic [AW-1:0] req_adr_i,
   output logic [AW-1:0] wbm_adr_o,
   output logic [DW-1:0] wbm_dat_o,
   output logic [3:0]    wbm_sel_o,
   output logic          wbm_we_o,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   output logic [2:0]    wbm_cti_o,
   output logic [1:0]    wbm_bte_o,
   input  logic [DW-1:0] wbm_dat_i,
   input  logic          wbm_ack_i,
   input  logic          wbm_err_i,
   input  logic          wbm_rty_i,
   output logic          rd_valid_o,
   output logic [DW-1:0] rd_dat_o,
   output logic [3:0]    rd_idx_o,
   output logic          rd_last_o,
   output logic          done_o,
   output logic          err_o
);

   localparam int IW = $clog2(BEATS);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] BTE = (BEATS == 16) ? 2'b11 :
                                (BEATS == 8)  ? 2'b10 : 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      LAST,
      FINISH
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] adr_q;
   logic [IW-1:0] beat_q;
   logic [TW-1:0] tmo_q;
   logic          err_q;
   logic          rd_valid_q;
   logic [DW-1:0] rd_dat_q;
   logic [3:0]    rd_idx_q;
   logic          rd_last_q;

   logic          active;
   logic          fail;
   logic          good_ack;
   logic          tmo_hit;
   logic          last_beat;
   logic [IW-1:0] word_nxt;

   assign active    = (state_q == BURST) || (state_q == LAST);
   // err/rty win over a simultaneous ack
   assign fail      = active && (wbm_err_i || wbm_rty_i);
   assign good_ack  = active && wbm_ack_i && !fail;
   assign tmo_hit   = active && !fail && !good_ack &&
                      (tmo_q == TW'(TIMEOUT - 1));
   assign last_beat = (beat_q == IW'(BEATS - 2));
   assign word_nxt  = adr_q[IW+1:2] + IW'(1);

   assign wbm_adr_o  = adr_q;
   assign wbm_dat_o  = '0;
   assign wbm_sel_o  = 4'hf;
   assign wbm_we_o   = 1'b0;
   assign wbm_bte_o  = BTE;
   assign rd_valid_o = rd_valid_q;
   assign rd_dat_o   = rd_dat_q;
   assign rd_idx_o   = rd_idx_q;
   assign rd_last_o  = rd_last_q;

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      wbm_cyc_o   = 1'b0;
      wbm_stb_o   = 1'b0;
      wbm_cti_o   = 3'b000;
      done_o      = 1'b0;
      err_o       = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready_o = wb_rst_n_i;
            if (req_valid_i) state_d = BURST;
         end
         BURST: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_cti_o = 3'b010;
            if (fail || tmo_hit)
               state_d = FINISH;
            else if (good_ack && last_beat)
               state_d = LAST;
         end
         LAST: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_cti_o = 3'b111;
            if (fail || tmo_hit || good_ack)
               state_d = FINISH;
         end
         FINISH: begin
            done_o  = 1'b1;
            err_o   = err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q    <= IDLE;
         adr_q      <= '0;
         beat_q     <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_dat_q   <= '0;
         rd_idx_q   <= '0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         if (state_q == IDLE && req_valid_i) begin
            adr_q  <= req_adr_i & ~AW'(3);
            beat_q <= '0;
            tmo_q  <= '0;
            err_q  <= 1'b0;
         end else if (active) begin
            if (fail || tmo_hit) begin
               err_q <= 1'b1;
            end else if (good_ack) begin
               beat_q        <= beat_q + IW'(1);
               adr_q[IW+1:2] <= word_nxt;
               tmo_q         <= '0;
               rd_valid_q    <= 1'b1;
               rd_dat_q      <= wbm_dat_i;
               rd_idx_q      <= 4'(adr_q[IW+1:2]);
               rd_last_q     <= (state_q == LAST);
            end else begin
               tmo_q <= tmo_q + TW'(1);
            end
         end else if (state_q == FINISH) begin
            err_q <= 1'b0;
         end
      end
   end

endmodule
